// File: rtl/imem_prog_loader.sv
// Loadable instruction memory for the IF stage.
// A streaming loader fills a synchronous RAM while in LOAD. Once the final
// word is accepted the block moves to RUN, where byte-addressed fetches are
// served with one cycle of latency. Misaligned and out-of-range fetches are
// flagged on addr_err and return NOP_WORD.
module imem_prog_loader #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 128,
  parameter int unsigned      ADDR_W   = 32,
  parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  // fetch port
  input  logic [ADDR_W-1:0]          adrs,
  input  logic                       fetch_en,
  output logic [WIDTH-1:0]           inst,
  output logic                       inst_valid,
  output logic                       addr_err,
  // loader port
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [WIDTH-1:0]           ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic [$clog2(DEPTH+1)-1:0] ld_count,
  output logic                       ld_ovf,
  output logic                       busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             inst_valid_q, inst_valid_d;
  logic             addr_err_q, addr_err_d;

  // RAM storage and its registered read data (no reset, so it maps to RAM)
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Fetch address decode; the range check uses the full word index so
  // that addresses at or beyond 4*DEPTH never alias onto low words.
  logic [ADDR_W-1:0] word_idx;
  logic              align_err;
  logic              range_err;
  logic              fetch_err;
  logic [IDX_W-1:0]  rd_idx;

  // Loader / fetch qualifiers
  logic             in_load;
  logic             in_run;
  logic             ld_accept;
  logic             has_room;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             fetch_cap;
  logic             rd_en;

  // Decode fetch address and qualify loader and fetch activity
  always_comb begin
    word_idx  = {2'b00, adrs[ADDR_W-1:2]};
    align_err = |adrs[1:0];
    range_err = (word_idx >= ADDR_W'(DEPTH));
    fetch_err = align_err | range_err;
    rd_idx    = word_idx[IDX_W-1:0];

    in_load   = (state_q == ST_LOAD);
    in_run    = (state_q == ST_RUN);
    ld_accept = in_load & ld_valid;
    has_room  = (ptr_q < CNT_W'(DEPTH));
    // A reset edge must not commit a word: the load is aborted, not extended.
    wr_en     = ld_accept & has_room & ~rst;
    wr_idx    = ptr_q[IDX_W-1:0];

    // ld_start takes priority over a fetch requested in the same cycle.
    fetch_cap = in_run & fetch_en & ~ld_start;
    rd_en     = fetch_cap & ~fetch_err & ~rst;
  end

  // Next-state logic for the LOAD/RUN controller and its registered outputs
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ovf_d        = ovf_q;
    inst_valid_d = inst_valid_q;
    addr_err_d   = addr_err_q;

    unique case (state_q)
      ST_LOAD: begin
        inst_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        if (ld_accept) begin
          if (has_room) begin
            ptr_d = ptr_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (ld_last) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (ld_start) begin
          state_d      = ST_LOAD;
          ptr_d        = '0;
          ovf_d        = 1'b0;
          inst_valid_d = 1'b0;
          addr_err_d   = 1'b0;
        end else if (fetch_en) begin
          inst_valid_d = ~fetch_err;
          addr_err_d   = fetch_err;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Controller state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Single write port (loader) and single synchronous read port (fetch)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= ld_data;
    end
    if (rd_en) begin
      rd_q <= mem[rd_idx];
    end
  end

  // rd_q only updates on good fetches and holds otherwise; the valid flag
  // masks it to NOP_WORD after errors, reset and while loading.
  assign inst       = inst_valid_q ? rd_q : NOP_WORD;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign ld_ready   = in_load;
  assign busy       = in_load;
  assign ld_count   = ptr_q;
  assign ld_ovf     = ovf_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: default-size instance for load, fetch,
// stall and reload behaviour, plus a DEPTH=4 instance for overflow.
module tb_imem_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-size instance signals
  logic        rst = 1'b1;
  logic [31:0] adrs = '0;
  logic        fetch_en = 1'b0;
  logic [31:0] inst;
  logic        inst_valid, addr_err;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, ld_ovf, busy;
  logic [7:0]  ld_count;

  // DEPTH=4 instance signals
  logic        s_rst = 1'b1;
  logic [31:0] s_adrs = '0;
  logic        s_fetch_en = 1'b0;
  logic [31:0] s_inst;
  logic        s_inst_valid, s_addr_err;
  logic        s_ld_valid = 1'b0, s_ld_last = 1'b0;
  logic [31:0] s_ld_data = '0;
  logic        s_ld_ready, s_ld_ovf, s_busy;
  logic [2:0]  s_ld_count;

  imem_prog_loader #(.WIDTH(32), .DEPTH(128), .ADDR_W(32), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .adrs(adrs), .fetch_en(fetch_en), .inst(inst),
    .inst_valid(inst_valid), .addr_err(addr_err), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count), .ld_ovf(ld_ovf), .busy(busy)
  );

  imem_prog_loader #(.WIDTH(32), .DEPTH(4), .ADDR_W(32), .NOP_WORD(32'h0)) dut4 (
    .clk(clk), .rst(s_rst), .adrs(s_adrs), .fetch_en(s_fetch_en), .inst(s_inst),
    .inst_valid(s_inst_valid), .addr_err(s_addr_err), .ld_start(1'b0),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last),
    .ld_ready(s_ld_ready), .ld_count(s_ld_count), .ld_ovf(s_ld_ovf), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance one clock, then sample 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fetch_en;
    logic [31:0] adrs;
    logic [31:0] inst;
    logic        valid;
    logic        err;
  } vec_t;

  localparam logic [31:0] W0 = 32'h8001060A;
  localparam logic [31:0] W1 = 32'h04011000;
  localparam logic [31:0] W2 = 32'h0C011800;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b1, 32'd4,          W1,    1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'd8,          W2,    1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'd2,          32'h0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'd512,        32'h0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'd0,          W0,    1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'd4,          W1,    1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'd8,          W1,    1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'd8,          W1,    1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'd8,          W1,    1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0004,  32'h0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'd508,        32'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'd513,        32'h0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'd0,          32'h0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'd8,          W2,    1'b1, 1'b0};
    // word 127 is never written; probe the error-free path on a known word
    vecs[10] = '{1'b1, 32'd0,          W0,    1'b1, 1'b0};

    // ---------------- reset ----------------
    step(); step();
    rst = 1'b0; s_rst = 1'b0;
    check("rst_busy",       32'(busy),       32'd1);
    check("rst_ld_ready",   32'(ld_ready),   32'd1);
    check("rst_ld_count",   32'(ld_count),   32'd0);
    check("rst_ld_ovf",     32'(ld_ovf),     32'd0);
    check("rst_inst",       inst,            32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_addr_err",   32'(addr_err),   32'd0);

    // ---------------- load 3 words ----------------
    ld_valid = 1'b1; ld_data = W0; fetch_en = 1'b1; adrs = 32'd0;
    step();
    check("ld1_count", 32'(ld_count), 32'd1);
    check("ld1_busy",  32'(busy),     32'd1);
    check("ld1_valid_in_load", 32'(inst_valid), 32'd0);
    ld_data = W1;
    step();
    check("ld2_count", 32'(ld_count), 32'd2);
    ld_data = W2; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ld3_count", 32'(ld_count), 32'd3);
    check("ld3_busy",  32'(busy),     32'd0);
    check("ld3_ovf",   32'(ld_ovf),   32'd0);
    check("ld3_ready", 32'(ld_ready), 32'd0);

    // ---------------- fetch vectors ----------------
    for (int i = 0; i < 14; i++) begin
      fetch_en = vecs[i].fetch_en;
      adrs     = vecs[i].adrs;
      step();
      check($sformatf("vec%0d_inst", i),  inst,             vecs[i].inst);
      check($sformatf("vec%0d_valid", i), 32'(inst_valid),  32'(vecs[i].valid));
      check($sformatf("vec%0d_err", i),   32'(addr_err),    32'(vecs[i].err));
    end

    // ld_valid in RUN must not change anything
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; fetch_en = 1'b1; adrs = 32'd0;
    step();
    ld_valid = 1'b0;
    check("run_ldvalid_count", 32'(ld_count), 32'd3);
    check("run_ldvalid_inst",  inst,          W0);

    // ---------------- ld_start together with fetch_en ----------------
    ld_start = 1'b1; fetch_en = 1'b1; adrs = 32'd4;
    step();
    ld_start = 1'b0; fetch_en = 1'b0;
    check("start_busy",  32'(busy),       32'd1);
    check("start_valid", 32'(inst_valid), 32'd0);
    check("start_inst",  inst,            32'h0);
    check("start_err",   32'(addr_err),   32'd0);
    check("start_count", 32'(ld_count),   32'd0);

    // ---------------- mid-load reset ----------------
    ld_valid = 1'b1; ld_data = 32'h1111_1111;
    step();
    ld_data = 32'h2222_2222;
    step();
    check("mid_count2", 32'(ld_count), 32'd2);
    ld_data = 32'h3333_3333; rst = 1'b1;
    step();
    rst = 1'b0; ld_valid = 1'b0;
    check("mid_rst_busy",  32'(busy),     32'd1);
    check("mid_rst_count", 32'(ld_count), 32'd0);
    ld_valid = 1'b1; ld_data = 32'h4444_4444; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("reload_busy",  32'(busy),     32'd0);
    check("reload_count", 32'(ld_count), 32'd1);
    fetch_en = 1'b1; adrs = 32'd4;
    step();
    check("reload_keep_w1", inst,            32'h2222_2222);
    check("reload_valid",   32'(inst_valid), 32'd1);
    adrs = 32'd0;
    step();
    check("reload_w0", inst, 32'h4444_4444);
    adrs = 32'd8;
    step();
    check("reload_w2_untouched", inst, 32'h3333_3333 ^ 32'h3333_3333 ^ W2);
    fetch_en = 1'b0;

    // ---------------- DEPTH=4 overflow ----------------
    s_ld_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      s_ld_data = 32'hA000_0000 + 32'(k);
      s_ld_last = (k == 6);
      step();
      if (k == 4) begin
        check("d4_count4", 32'(s_ld_count), 32'd4);
        check("d4_ovf4",   32'(s_ld_ovf),   32'd0);
      end
      if (k == 5) begin
        check("d4_ovf5",   32'(s_ld_ovf),   32'd1);
        check("d4_busy5",  32'(s_busy),     32'd1);
      end
    end
    s_ld_valid = 1'b0; s_ld_last = 1'b0;
    check("d4_count_end", 32'(s_ld_count), 32'd4);
    check("d4_busy_end",  32'(s_busy),     32'd0);
    s_fetch_en = 1'b1; s_adrs = 32'd12;
    step();
    check("d4_ovf_sticky", 32'(s_ld_ovf),     32'd1);
    check("d4_fetch12",    s_inst,            32'hA000_0004);
    check("d4_fetch12_v",  32'(s_inst_valid), 32'd1);
    s_adrs = 32'd16;
    step();
    check("d4_fetch16_err",  32'(s_addr_err),   32'd1);
    check("d4_fetch16_inst", s_inst,            32'h0);
    check("d4_fetch16_v",    32'(s_inst_valid), 32'd0);
    s_fetch_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
